// File: rtl/ts_rx_decoder_pkg.sv
// ============================================================================
// Module : ts_rx_decoder_pkg
// Brief  : Symbol constants, TS type / FSM encodings and a symbol-extract
//          helper shared by the TS receive decoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ts_rx_decoder_pkg;

    localparam logic [7:0] COM       = 8'hBC;
    localparam logic [7:0] PADG12    = 8'hF7;
    localparam logic [7:0] TS1_IDTFR = 8'h4A;
    localparam logic [7:0] TS2_IDTFR = 8'h45;

    typedef enum logic [1:0] {
        TS_NONE = 2'b00,
        TS_T1   = 2'b01,
        TS_T2   = 2'b10
    } ts_type_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_TRACK  = 2'b01,
        S_REPORT = 2'b10
    } state_e;

    // Symbol 0 lives in the most significant byte of the 128-bit word.
    function automatic logic [7:0] ts_sym(input logic [127:0] ts, input int idx);
        return ts[127 - 8*idx -: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ts_rx_decoder_if.sv
// ============================================================================
// Module : ts_rx_decoder_if
// Brief  : Link/lane number report handshake between the TS receive decoder
//          (master) and the TS generator (slave).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ts_rx_decoder_if;
    logic [7:0] rcv_link_num;
    logic       rcv_link_num_vld;
    logic [7:0] rcv_lane_num;
    logic       rcv_lane_num_vld;
    logic       update_ack;

    modport master (
        output rcv_link_num,
        output rcv_link_num_vld,
        output rcv_lane_num,
        output rcv_lane_num_vld,
        input  update_ack
    );

    modport slave (
        input  rcv_link_num,
        input  rcv_link_num_vld,
        input  rcv_lane_num,
        input  rcv_lane_num_vld,
        output update_ack
    );
endinterface

`default_nettype wire

// File: rtl/ts_rx_classify.sv
// ============================================================================
// Module : ts_rx_classify
// Brief  : Combinational TS1/TS2/malformed classifier; also breaks out the
//          header symbols 1..5 used for identity tracking and reporting.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_rx_classify
    import ts_rx_decoder_pkg::*;
(
    input  logic [127:0] ts_in,
    output logic         is_ts1,
    output logic         is_ts2,
    output logic         is_bad,
    output logic [7:0]   sym1,
    output logic [7:0]   sym2,
    output logic [7:0]   sym3,
    output logic [7:0]   sym4,
    output logic [7:0]   sym5
);

    always_comb begin
        is_ts1 = (ts_sym(ts_in, 0) == COM);
        is_ts2 = is_ts1;
        for (int i = 6; i < 16; i++) begin
            is_ts1 = is_ts1 && (ts_sym(ts_in, i) == TS1_IDTFR);
            is_ts2 = is_ts2 && (ts_sym(ts_in, i) == TS2_IDTFR);
        end
        is_bad = !(is_ts1 || is_ts2);
    end

    assign sym1 = ts_sym(ts_in, 1);
    assign sym2 = ts_sym(ts_in, 2);
    assign sym3 = ts_sym(ts_in, 3);
    assign sym4 = ts_sym(ts_in, 4);
    assign sym5 = ts_sym(ts_in, 5);

endmodule

`default_nettype wire

// File: rtl/ts_rx_decoder.sv
// ============================================================================
// Module : ts_rx_decoder
// Brief  : Receive-side TS decoder: classifies and counts TS1/TS2 words and
//          reports link/lane numbers to the TS generator over vld/ack.
//          Define TS_RX_ERR_CNT_EN to build the malformed-TS counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_rx_decoder
    import ts_rx_decoder_pkg::*;
#(
    parameter int CONSEC_NUM = 2,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [127:0]       ts_in,
    input  logic               ts_in_valid,
    input  logic               clr,
    input  logic [CNT_W-1:0]   rcv_target,
    output logic [1:0]         ts_type,
    output logic [CNT_W-1:0]   rcv_cnt,
    output logic [3:0]         consec_cnt,
    output logic               rcv_enough,
    output logic [5:0]         rcv_rate,
    ts_rx_decoder_if.master    rpt,
    output logic [7:0]         err_cnt
);

    localparam logic [3:0] CONSEC_THR = 4'(CONSEC_NUM);

    logic        is_ts1, is_ts2, is_bad;
    logic [7:0]  sym1, sym2, sym3, sym4, sym5;
    logic        w_good;
    ts_type_e    w_type_in;
    logic [39:0] w_hdr;
    logic [7:0]  w_link, w_lane;
    logic        w_qual, w_load;

    state_e           state_q, state_d;
    ts_type_e         ts_type_q, ts_type_d;
    logic [CNT_W-1:0] rcv_cnt_q, rcv_cnt_d;
    logic [3:0]       consec_q, consec_d;
    logic [5:0]       rate_q, rate_d;
    logic [39:0]      prev_q, prev_d;
    logic [7:0]       link_num_q, link_num_d, lane_num_q, lane_num_d;
    logic             link_vld_q, link_vld_d, lane_vld_q, lane_vld_d;
    logic [7:0]       last_link_q, last_link_d, last_lane_q, last_lane_d;
    logic             last_vld_q, last_vld_d;

    ts_rx_classify u_classify (
        .ts_in  (ts_in),
        .is_ts1 (is_ts1),
        .is_ts2 (is_ts2),
        .is_bad (is_bad),
        .sym1   (sym1),
        .sym2   (sym2),
        .sym3   (sym3),
        .sym4   (sym4),
        .sym5   (sym5)
    );

    assign w_good    = ts_in_valid && !is_bad;
    assign w_type_in = is_ts1 ? TS_T1 : (is_ts2 ? TS_T2 : TS_NONE);
    assign w_hdr     = {sym1, sym2, sym3, sym4, sym5};

    // Counting and header tracking.
    always_comb begin
        ts_type_d = ts_type_q;
        rcv_cnt_d = rcv_cnt_q;
        consec_d  = consec_q;
        rate_d    = rate_q;
        prev_d    = prev_q;
        if (clr) begin
            ts_type_d = TS_NONE;
            rcv_cnt_d = '0;
            consec_d  = '0;
            prev_d    = '0;
        end else if (w_good) begin
            if (w_type_in != ts_type_q) begin
                ts_type_d = w_type_in;
                rcv_cnt_d = CNT_W'(1);
                consec_d  = 4'd1;
            end else begin
                rcv_cnt_d = (&rcv_cnt_q) ? rcv_cnt_q : rcv_cnt_q + 1'b1;
                if (w_hdr == prev_q) begin
                    consec_d = (&consec_q) ? consec_q : consec_q + 4'd1;
                end else begin
                    consec_d = 4'd1;
                end
            end
            prev_d = w_hdr;
            rate_d = sym4[5:0];
        end else if (ts_in_valid) begin
            consec_d = '0;
        end
    end

    // A report is due once the streak is long enough, the numbers are not
    // both PAD, and they differ from what the generator already consumed.
    // Evaluated as a level so a report suppressed by a coincident ack is
    // re-issued from the stored header once back in S_TRACK.
    assign w_link = prev_d[39:32];
    assign w_lane = prev_d[31:24];
    assign w_qual = (consec_d >= CONSEC_THR)
                 && ((w_link != PADG12) || (w_lane != PADG12))
                 && (!last_vld_q || (w_link != last_link_q) || (w_lane != last_lane_q));
    assign w_load = !clr && (state_q != S_REPORT) && w_qual;

    always_comb begin
        state_d     = state_q;
        link_num_d  = link_num_q;
        lane_num_d  = lane_num_q;
        link_vld_d  = link_vld_q;
        lane_vld_d  = lane_vld_q;
        last_link_d = last_link_q;
        last_lane_d = last_lane_q;
        last_vld_d  = last_vld_q;
        if (clr) begin
            state_d     = S_IDLE;
            link_vld_d  = 1'b0;
            lane_vld_d  = 1'b0;
            last_link_d = '0;
            last_lane_d = '0;
            last_vld_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_good) state_d = S_TRACK;
                end
                S_TRACK: begin
                    state_d = S_TRACK;
                end
                S_REPORT: begin
                    if (rpt.update_ack) begin
                        link_vld_d = 1'b0;
                        lane_vld_d = 1'b0;
                        state_d    = S_TRACK;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (w_load) begin
                link_num_d  = w_link;
                lane_num_d  = w_lane;
                link_vld_d  = (w_link != PADG12);
                lane_vld_d  = (w_lane != PADG12);
                last_link_d = w_link;
                last_lane_d = w_lane;
                last_vld_d  = 1'b1;
                state_d     = S_REPORT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ts_type_q   <= TS_NONE;
            rcv_cnt_q   <= '0;
            consec_q    <= '0;
            rate_q      <= '0;
            prev_q      <= '0;
            link_num_q  <= '0;
            lane_num_q  <= '0;
            link_vld_q  <= 1'b0;
            lane_vld_q  <= 1'b0;
            last_link_q <= '0;
            last_lane_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_type_q   <= ts_type_d;
            rcv_cnt_q   <= rcv_cnt_d;
            consec_q    <= consec_d;
            rate_q      <= rate_d;
            prev_q      <= prev_d;
            link_num_q  <= link_num_d;
            lane_num_q  <= lane_num_d;
            link_vld_q  <= link_vld_d;
            lane_vld_q  <= lane_vld_d;
            last_link_q <= last_link_d;
            last_lane_q <= last_lane_d;
            last_vld_q  <= last_vld_d;
        end
    end

`ifdef TS_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr) begin
            err_cnt_d = '0;
        end else if (ts_in_valid && is_bad && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign ts_type              = ts_type_q;
    assign rcv_cnt              = rcv_cnt_q;
    assign consec_cnt           = consec_q;
    assign rcv_rate             = rate_q;
    assign rcv_enough           = (rcv_cnt_q >= rcv_target) && (rcv_target != '0);
    assign rpt.rcv_link_num     = link_num_q;
    assign rpt.rcv_link_num_vld = link_vld_q;
    assign rpt.rcv_lane_num     = lane_num_q;
    assign rpt.rcv_lane_num_vld = lane_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_ts_rx_decoder.sv
// ============================================================================
// Module : tb_ts_rx_decoder
// Brief  : Self-checking bench for ts_rx_decoder: directed scenarios plus a
//          randomized run against a behavioural reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ts_rx_decoder;

    localparam int CONSEC_NUM = 2;
    localparam int CNT_W      = 16;
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_PAD = 8'hF7;
    localparam logic [7:0] K_T1  = 8'h4A;
    localparam logic [7:0] K_T2  = 8'h45;

    logic             clk = 1'b0;
    logic             rst;
    logic [127:0]     ts_in;
    logic             ts_in_valid;
    logic             clr;
    logic [CNT_W-1:0] rcv_target;
    logic [1:0]       ts_type;
    logic [CNT_W-1:0] rcv_cnt;
    logic [3:0]       consec_cnt;
    logic             rcv_enough;
    logic [5:0]       rcv_rate;
    logic [7:0]       err_cnt;

    ts_rx_decoder_if rpt ();

    ts_rx_decoder #(.CONSEC_NUM(CONSEC_NUM), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ts_in       (ts_in),
        .ts_in_valid (ts_in_valid),
        .clr         (clr),
        .rcv_target  (rcv_target),
        .ts_type     (ts_type),
        .rcv_cnt     (rcv_cnt),
        .consec_cnt  (consec_cnt),
        .rcv_enough  (rcv_enough),
        .rcv_rate    (rcv_rate),
        .rpt         (rpt.master),
        .err_cnt     (err_cnt)
    );

    always #1 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_type, m_cnt, m_consec, m_rate, m_err;
    logic [7:0] m_prev [1:5];
    bit         m_reporting, m_link_vld, m_lane_vld, m_last_vld;
    logic [7:0] m_link, m_lane, m_last_link, m_last_lane;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_ts(input logic [7:0] id, input logic [7:0] link,
                                          input logic [7:0] lane, input logic [7:0] rate);
        logic [127:0] t;
        t = '0;
        t[127 -: 8] = K_COM;
        t[119 -: 8] = link;
        t[111 -: 8] = lane;
        t[103 -: 8] = 8'hFF;
        t[95  -: 8] = rate;
        t[87  -: 8] = 8'h00;
        for (int i = 6; i < 16; i++) t[127 - 8*i -: 8] = id;
        return t;
    endfunction

    task automatic model_reset();
        m_type = 0; m_cnt = 0; m_consec = 0; m_rate = 0; m_err = 0;
        for (int i = 1; i <= 5; i++) m_prev[i] = 8'h00;
        m_reporting = 0; m_link_vld = 0; m_lane_vld = 0; m_last_vld = 0;
        m_link = 0; m_lane = 0; m_last_link = 0; m_last_lane = 0;
    endtask

    task automatic model_step(input logic [127:0] ts, input bit v, input bit c, input bit ack);
        logic [7:0] s [0:15];
        int  n1, n2, t;
        bit  same;
        for (int i = 0; i < 16; i++) s[i] = ts[127 - 8*i -: 8];
        if (c) begin
            m_type = 0; m_cnt = 0; m_consec = 0; m_err = 0;
            for (int i = 1; i <= 5; i++) m_prev[i] = 8'h00;
            m_reporting = 0; m_link_vld = 0; m_lane_vld = 0;
            m_last_vld = 0; m_last_link = 0; m_last_lane = 0;
            return;
        end
        n1 = 0; n2 = 0;
        for (int i = 6; i < 16; i++) begin
            if (s[i] == K_T1) n1++;
            if (s[i] == K_T2) n2++;
        end
        t = 0;
        if (s[0] == K_COM && n1 == 10) t = 1;
        if (s[0] == K_COM && n2 == 10) t = 2;
        if (v && t != 0) begin
            same = 1;
            for (int i = 1; i <= 5; i++) if (s[i] != m_prev[i]) same = 0;
            if (t != m_type) begin
                m_type = t; m_cnt = 1; m_consec = 1;
            end else begin
                m_cnt    = (m_cnt == 65535) ? 65535 : m_cnt + 1;
                m_consec = same ? ((m_consec == 15) ? 15 : m_consec + 1) : 1;
            end
            for (int i = 1; i <= 5; i++) m_prev[i] = s[i];
            m_rate = int'(s[4]) % 64;
        end else if (v) begin
            m_consec = 0;
            m_err    = (m_err == 255) ? 255 : m_err + 1;
        end
        if (m_reporting) begin
            if (ack) begin
                m_reporting = 0; m_link_vld = 0; m_lane_vld = 0;
            end
        end else if (m_consec >= CONSEC_NUM
                     && !(m_prev[1] == K_PAD && m_prev[2] == K_PAD)
                     && (!m_last_vld || m_prev[1] != m_last_link || m_prev[2] != m_last_lane)) begin
            m_reporting = 1;
            m_link = m_prev[1]; m_lane = m_prev[2];
            m_link_vld = (m_prev[1] != K_PAD);
            m_lane_vld = (m_prev[2] != K_PAD);
            m_last_vld = 1; m_last_link = m_prev[1]; m_last_lane = m_prev[2];
        end
    endtask

    task automatic check_all(input string tag);
        int exp_err;
`ifdef TS_RX_ERR_CNT_EN
        exp_err = m_err;
`else
        exp_err = 0;
`endif
        chk({tag, ":ts_type"},  32'(ts_type),    m_type);
        chk({tag, ":rcv_cnt"},  32'(rcv_cnt),    m_cnt);
        chk({tag, ":consec"},   32'(consec_cnt), m_consec);
        chk({tag, ":enough"},   32'(rcv_enough), 32'((m_cnt >= int'(rcv_target)) && (rcv_target != 0)));
        chk({tag, ":rate"},     32'(rcv_rate),   m_rate);
        chk({tag, ":link_vld"}, 32'(rpt.rcv_link_num_vld), 32'(m_link_vld));
        chk({tag, ":lane_vld"}, 32'(rpt.rcv_lane_num_vld), 32'(m_lane_vld));
        chk({tag, ":link"},     32'(rpt.rcv_link_num), 32'(m_link));
        chk({tag, ":lane"},     32'(rpt.rcv_lane_num), 32'(m_lane));
        chk({tag, ":err_cnt"},  32'(err_cnt),    exp_err);
    endtask

    task automatic step(input string tag, input logic [127:0] ts, input bit v,
                        input bit c, input bit ack);
        ts_in = ts; ts_in_valid = v; clr = c; rpt.update_ack = ack;
        @(posedge clk); #0.5;
        model_step(ts, v, c, ack);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; ts_in_valid = 1'b0; clr = 1'b0; rpt.update_ack = 1'b0;
        @(posedge clk); #0.5;
        model_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    logic [127:0] ts_a, ts_b, ts_bad, ts_r;
    logic [7:0]   r_link, r_lane, r_rate;
    logic [7:0]   r_id;

    initial begin
        rst = 1'b1; ts_in = '0; ts_in_valid = 1'b0; clr = 1'b0;
        rcv_target = '0; rpt.update_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset("reset");

        // 1: four identical TS1 with PAD link/lane, ack ignored while tracking
        ts_a = mk_ts(K_T1, K_PAD, K_PAD, 8'h06);
        for (int i = 0; i < 4; i++) step("t1", ts_a, 1, 0, i == 2);
        chk("t1_cnt4", 32'(rcv_cnt), 4);
        chk("t1_consec4", 32'(consec_cnt), 4);
        for (int i = 0; i < 13; i++) step("t1_sat", ts_a, 1, 0, 0);
        chk("t1_consec_sat", 32'(consec_cnt), 15);

        // 2: link 05 reported after 2nd TS, held without ack, drops after ack
        step("t2_clr", ts_a, 0, 1, 0);
        ts_b = mk_ts(K_T1, 8'h05, K_PAD, 8'h06);
        step("t2", ts_b, 1, 0, 0);
        step("t2", ts_b, 1, 0, 0);
        chk("t2_link_vld", 32'(rpt.rcv_link_num_vld), 1);
        chk("t2_link", 32'(rpt.rcv_link_num), 32'h05);
        for (int i = 0; i < 10; i++) step("t2_hold", ts_b, 0, 0, 0);
        step("t2_ack", ts_b, 0, 0, 1);
        chk("t2_vld_drop", 32'(rpt.rcv_link_num_vld), 0);

        // 3: malformed TS in the middle of a run
        step("t3_clr", ts_a, 0, 1, 0);
        ts_bad = ts_a;
        ts_bad[127 - 8*9 -: 8] = 8'h00;
        step("t3", ts_a, 1, 0, 0);
        step("t3", ts_a, 1, 0, 0);
        step("t3", ts_bad, 1, 0, 0);
        chk("t3_consec0", 32'(consec_cnt), 0);
        step("t3", ts_a, 1, 0, 0);
        chk("t3_cnt3", 32'(rcv_cnt), 3);

        // 4: rcv_enough after 8 TS2, then clr beats a same-cycle TS
        step("t4_clr", ts_a, 0, 1, 0);
        rcv_target = 16'd8;
        ts_b = mk_ts(K_T2, K_PAD, K_PAD, 8'h02);
        for (int i = 0; i < 8; i++) step("t4", ts_b, 1, 0, 0);
        chk("t4_enough", 32'(rcv_enough), 1);
        step("t4_clr_ts", ts_b, 1, 1, 0);
        chk("t4_cnt0", 32'(rcv_cnt), 0);
        rcv_target = '0;

        // 5: repeated link 05 not re-reported; link 07 is
        step("t5_clr", ts_a, 0, 1, 0);
        ts_b = mk_ts(K_T1, 8'h05, 8'h01, 8'h06);
        step("t5", ts_b, 1, 0, 0);
        step("t5", ts_b, 1, 0, 0);
        step("t5_ack", ts_b, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("t5_same", ts_b, 1, 0, 0);
        chk("t5_no_vld", 32'(rpt.rcv_link_num_vld), 0);
        ts_b = mk_ts(K_T1, 8'h07, 8'h01, 8'h06);
        step("t5_new", ts_b, 1, 0, 0);
        step("t5_new", ts_b, 1, 0, 0);
        chk("t5_link07", 32'(rpt.rcv_link_num), 32'h07);

        // ack coinciding with a new qualifying TS
        ts_b = mk_ts(K_T1, 8'h0A, 8'h02, 8'h06);
        step("col", ts_b, 1, 0, 0);
        step("col_ack", ts_b, 1, 0, 1);
        for (int i = 0; i < 3; i++) step("col_after", ts_b, 0, 0, 0);
        chk("col_link0A", 32'(rpt.rcv_link_num), 32'h0A);

        // Randomized run
        step("rnd_clr", ts_a, 0, 1, 0);
        r_link = 8'h05; r_lane = 8'h02; r_rate = 8'h06; r_id = K_T1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(2))
                    0:       r_link = 8'h05;
                    1:       r_link = 8'h07;
                    default: r_link = K_PAD;
                endcase
                r_lane = ($urandom_range(1) == 0) ? K_PAD : 8'h02;
                r_id   = ($urandom_range(4) == 0) ? K_T2 : K_T1;
                r_rate = 8'($urandom_range(255));
            end
            ts_r = mk_ts(r_id, r_link, r_lane, r_rate);
            if ($urandom_range(5) == 0) begin
                if ($urandom_range(1) == 0) ts_r[127 -: 8] = 8'($urandom_range(255));
                else ts_r[127 - 8*$urandom_range(15, 6) -: 8] = 8'($urandom_range(255));
            end
            if ($urandom_range(15) == 0) rcv_target = 16'($urandom_range(6));
            step("rnd", ts_r, $urandom_range(3) != 0, $urandom_range(39) == 0,
                 $urandom_range(3) == 0);
        end

        // 6: reset while a report is pending
        step("t6_clr", ts_a, 0, 1, 0);
        ts_b = mk_ts(K_T1, 8'h05, K_PAD, 8'h06);
        step("t6", ts_b, 1, 0, 0);
        step("t6", ts_b, 1, 0, 0);
        chk("t6_vld_before", 32'(rpt.rcv_link_num_vld), 1);
        do_reset("t6_rst");
        step("t6_first", ts_b, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ts_rx_decoder.md
Name: ts_rx_decoder

Overview:
- Receive-side counterpart of the TS generator. Accepts 128-bit training-set words (16 symbols, symbol 0 in bits [127:120]) from the RX lane path.
- Classifies each word as TS1, TS2 or malformed, and counts total and consecutive identical TSs.
- Extracts link and lane numbers and hands them to the TS generator over a vld/ack handshake.
- Reports "received enough" to the LTSSM FSM.

Parameters:
- CONSEC_NUM, 2: consecutive identical TSs required before link/lane numbers are reported.
- CNT_W, 16: width of the received-TS counter.

Ports:
- clk  in  1  1 GHz system clock
- rst  in  1  reset
- ts_in  in  128  received TS; symbol i is at bits [127-8i -: 8]
- ts_in_valid  in  1  ts_in valid this cycle; no backpressure
- clr  in  1  FSM state/substate change; clears all tracking
- rcv_target  in  CNT_W  required good-TS count for the current substate
- ts_type  out  2  type of last good TS: 00 none, 01 TS1, 10 TS2
- rcv_cnt  out  CNT_W  good TSs of current type since clr; saturating
- consec_cnt  out  4  consecutive identical good TSs; saturating at 15
- rcv_enough  out  1  rcv_cnt >= rcv_target and rcv_target != 0
- rcv_rate  out  6  symbol 4 bits [5:0] of last good TS
- rcv_link_num  out  8  reported link number
- rcv_link_num_vld  out  1  link number valid; held until ack
- rcv_lane_num  out  8  reported lane number
- rcv_lane_num_vld  out  1  lane number valid; held until ack
- update_ack  in  1  TS generator consumed vld
- err_cnt  out  8  malformed-TS counter (optional feature)

Behaviour:
- Reset is synchronous, active-high, on rst, clocked by clk. Every output resets to 0; the FSM resets to S_IDLE.
- Good TS:
  - sym0 == `COM.
  - sym6..sym15 are all equal and equal to `TS1_IDTFR (TS1) or `TS2_IDTFR (TS2).
  - Anything else is malformed.
- All outputs are registered. A TS accepted in cycle N is reflected in the outputs at N+1.
- Good TS, same type as ts_type, sym1..sym5 identical to the stored previous TS:
  - consec_cnt += 1 (saturating).
  - rcv_cnt += 1 (saturating at all-ones).
- Good TS, type changed:
  - ts_type updated; rcv_cnt = 1; consec_cnt = 1.
- Good TS, same type but sym1..sym5 differ:
  - consec_cnt = 1; rcv_cnt += 1.
- Malformed TS: consec_cnt = 0. rcv_cnt, ts_type and the stored TS are unchanged.
- FSM states:
  - S_IDLE: no good TS yet. The first good TS goes to S_TRACK.
  - S_TRACK: on the cycle consec_cnt becomes CONSEC_NUM, if sym1 != `PADG12 or sym2 != `PADG12, load the report registers and go to S_REPORT.
    - rcv_link_num = sym1, rcv_link_num_vld = (sym1 != `PADG12).
    - rcv_lane_num = sym2, rcv_lane_num_vld = (sym2 != `PADG12).
  - S_REPORT: vld flags and numbers are held stable until update_ack. Counting continues.
    - On update_ack: clear both vld, go to S_TRACK.
- After an ack, a new report is issued only if the qualifying sym1/sym2 differ from the last reported values, or after clr.
- clr: from any state, clear counters, ts_type, stored TS, vld flags and last-reported values; go to S_IDLE.
  - clr with ts_in_valid in the same cycle: clr wins and the TS is dropped.
- update_ack with a new qualifying TS in the same cycle: vld deasserts for at least one cycle, then re-asserts with the new values if they differ.
- update_ack in S_TRACK or S_IDLE is ignored.
- rcv_enough is combinational compare of registered rcv_cnt against rcv_target.

Optional Feature:
- TS_RX_ERR_CNT_EN defined:
  - err_cnt increments, saturating at 255, on each malformed TS with ts_in_valid.
  - Cleared by clr and by rst.
- Not defined: err_cnt is tied to 0 and no counter logic is generated.

Decomposition:
- define.v holds `COM, `PADG12, `TS1_IDTFR, `TS2_IDTFR, ts_type encodings (`TS_NONE/`TS_T1/`TS_T2) and FSM state encodings.
- Sub-module ts_rx_classify: purely combinational. Inputs ts_in; outputs is_ts1, is_ts2, is_bad, and sym1..sym5 fields. Instantiated once.

Test Plan:
- 1. 4× TS1 (`COM, F7, F7, FF, rate 06, 00, 10×`TS1_IDTFR`) -> at cycle after the 4th: ts_type=01, rcv_cnt=4, consec_cnt=4, no vld.
- 2. 2× TS1 with link=0x05, lane=F7 -> rcv_link_num=05 and rcv_link_num_vld=1 one cycle after the 2nd TS, lane vld=0. Vld held 10 cycles without ack; drops the cycle after update_ack.
- 3. TS1, TS1, corrupted TS (sym9=0x00), TS1 -> consec_cnt 1, 2, 0, 1; rcv_cnt=3. err_cnt=1 with TS_RX_ERR_CNT_EN, 0 without.
- 4. rcv_target=8, 8 good TS2 -> ts_type=10, rcv_enough rises after the 8th. clr with a 9th TS in the same cycle -> all counters 0, ts_type=00, the 9th TS is not counted.
- 5. Link 05 reported and acked, then 3 more TS1 with link 05 -> no new vld. Then 2× TS1 with link 07 -> new report 07.
- 6. rst asserted in S_REPORT with vld high -> next cycle all outputs 0, FSM in S_IDLE.
